// File: rtl/mux4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4x1_rr_arbiter
// Description : Round-robin arbiter sharing one 4:1 bit-select mux among four
//               requesters. Grants one requester at a time for a bounded
//               burst and drives the mux sel lines plus a one-hot grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4x1_rr_arbiter #(
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       selValid,
  output logic       lastCycle
);

  localparam logic [CNT_W-1:0] C_BURST = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q,   sel_d;
  logic [1:0]       ptr_q,   ptr_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Returns {found, index}: first set bit of r scanning p, p+1, p+2, p+3.
  // The loop runs downward so the nearest candidate overwrites the others.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // While granting, sel_q always names the current owner, so it doubles as
  // the owner index; the scan base after release is owner+1.
  logic [1:0] w_owner;
  logic [1:0] w_base;
  logic [2:0] w_pick;
  logic       w_release;

  assign w_owner   = sel_q;
  assign w_base    = (state_q == S_GRANT) ? (w_owner + 2'd1) : ptr_q;
  assign w_pick    = pick(req, w_base);
  assign w_release = (~req[w_owner]) | (cnt_q == C_BURST);

  // Next-state logic: idle acquisition, burst counting and owner hand-off.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_pick[2]) begin
          grant_d = 4'b0001 << w_pick[1:0];
          sel_d   = w_pick[1:0];
          cnt_d   = C_ONE;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          // Pointer moves past the releasing owner, making it lowest priority.
          ptr_d = w_owner + 2'd1;
          if (w_pick[2]) begin
            grant_d = 4'b0001 << w_pick[1:0];
            sel_d   = w_pick[1:0];
            cnt_d   = C_ONE;
          end else begin
            // sel deliberately holds so the mux keeps its last selection.
            grant_d = 4'b0000;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 4'b0000;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset that overrides any burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant     = grant_q;
  assign sel       = sel_q;
  assign selValid  = |grant_q;
  assign lastCycle = (state_q == S_GRANT) && (cnt_q == C_BURST);

endmodule
`default_nettype wire

// File: tb/tb_mux4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4x1_rr_arbiter
// Description : Scoreboard bench for mux4x1_rr_arbiter. Two instances
//               (BURST_LEN 4 and 1) share stimulus; a rule-level model
//               predicts outputs, a monitor compares them each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4x1_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] grant0, grant1;
  logic [1:0] sel0, sel1;
  logic       sv0, sv1, lc0, lc1;

  always #5 clk = ~clk;

  mux4x1_rr_arbiter #(.BURST_LEN(4), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant0), .sel(sel0), .selValid(sv0), .lastCycle(lc0)
  );

  mux4x1_rr_arbiter #(.BURST_LEN(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant1), .sel(sel1), .selValid(sv1), .lastCycle(lc1)
  );

  typedef struct packed {
    logic [7:0] grant;
    logic [3:0] sel;
    logic [1:0] sv;
    logic [1:0] lc;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Reference model: owner index (-1 = nobody), pointer, burst count.
  int bl      [2] = '{4, 1};
  int m_owner [2];
  int m_ptr   [2];
  int m_cnt   [2];
  int m_sel   [2];

  function automatic int pick_m(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input int d, input logic [3:0] r, input logic rst);
    int n;
    if (rst) begin
      m_owner[d] = -1; m_ptr[d] = 0; m_cnt[d] = 0; m_sel[d] = 0;
    end else if (m_owner[d] < 0) begin
      n = pick_m(r, m_ptr[d]);
      if (n >= 0) begin
        m_owner[d] = n; m_sel[d] = n; m_cnt[d] = 1;
      end
    end else if (!r[m_owner[d]] || m_cnt[d] == bl[d]) begin
      m_ptr[d] = (m_owner[d] + 1) % 4;
      n = pick_m(r, m_ptr[d]);
      if (n >= 0) begin
        m_owner[d] = n; m_sel[d] = n; m_cnt[d] = 1;
      end else begin
        m_owner[d] = -1;
      end
    end else begin
      m_cnt[d] = m_cnt[d] + 1;
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the outcome
  // expected after the following rising edge.
  task automatic drive(input logic [3:0] r, input logic rst);
    exp_t e;
    @(negedge clk);
    req   = r;
    reset = rst;
    cycle++;
    for (int d = 0; d < 2; d++) begin
      model_step(d, r, rst);
      e.grant[d*4 +: 4] = (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
      e.sel[d*2 +: 2]   = 2'(m_sel[d]);
      e.sv[d]           = (m_owner[d] >= 0);
      e.lc[d]           = (m_owner[d] >= 0) && (m_cnt[d] == bl[d]);
    end
    e.cyc = cycle;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int cyc, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  // Monitor: compares DUT outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant_bl4",     e.cyc, int'(grant0), int'(e.grant[3:0]));
        chk("sel_bl4",       e.cyc, int'(sel0),   int'(e.sel[1:0]));
        chk("selValid_bl4",  e.cyc, int'(sv0),    int'(e.sv[0]));
        chk("lastCycle_bl4", e.cyc, int'(lc0),    int'(e.lc[0]));
        chk("grant_bl1",     e.cyc, int'(grant1), int'(e.grant[7:4]));
        chk("sel_bl1",       e.cyc, int'(sel1),   int'(e.sel[3:2]));
        chk("selValid_bl1",  e.cyc, int'(sv1),    int'(e.sv[1]));
        chk("lastCycle_bl1", e.cyc, int'(lc1),    int'(e.lc[1]));
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic       rs;
    int         wait_cnt;

    // Reset held with all requesting, then rotation from ptr=0.
    repeat (2) drive(4'b1111, 1'b1);
    repeat (20) drive(4'b1111, 1'b0);
    // Drain to idle, then single-requester continuous bursts.
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    repeat (12) drive(4'b0100, 1'b0);
    // Early drop: requester 0 drops in its second grant cycle.
    drive(4'b0000, 1'b1);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0010, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    // Owner 3 expires with 1001 pending: pointer wraps to 0.
    drive(4'b0000, 1'b1);
    drive(4'b1000, 1'b0);
    repeat (3) drive(4'b1000, 1'b0);
    repeat (3) drive(4'b1001, 1'b0);
    // Reset in the middle of owner 2's burst, then a fresh burst.
    drive(4'b0000, 1'b1);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    repeat (8) drive(4'b0100, 1'b0);

    // Randomised traffic with held requests and occasional resets.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 99) == 0);
      drive(r, rs);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      #2;
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux4x1_rr_arbiter.md
# mux4x1_rr_arbiter

Round-robin arbiter that shares the single 4:1 bit-select mux between four requesters. It samples a 4-bit request vector, grants one requester at a time for a bounded burst, and drives the mux `sel` lines plus a one-hot grant back to the requesters. It sits directly in front of the mux. Its `sel` output connects straight to the mux `sel` input. Requester `i` owns mux data input `inputVal[i]`.

## Interface

Parameters:
- `BURST_LEN`, default 4: maximum consecutive cycles of one grant. Legal range is 1..15.
- `CNT_W`, default 4: width of the burst counter. Must hold `BURST_LEN`.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  4: request vector. `req[i]` is high while requester `i` wants the mux.
- `grant`  out  4: one-hot grant, or all-zero when idle. Registered.
- `sel`  out  2: binary encoding of the current/last owner, driven to the mux `sel`. Registered.
- `selValid`  out  1: high when `grant != 0`. The mux output `y` is meaningful only while this is high.
- `lastCycle`  out  1: high during the final permitted cycle of the current burst.

## Operation

Reset:
- Sampled at a rising edge with `reset`=1.
- Result: state IDLE, `grant`=0000, `sel`=00, pointer `ptr`=0, counter `cnt`=0.
- Reset overrides everything, including mid-burst. The owner loses its grant at that edge.

Pick function `pick(r, p)`:
- Returns the first index `j` in the order p, p+1, p+2, p+3 (mod 4) with `r[j]`=1.
- Result is "none" if `r`=0.

State IDLE, at each edge:
- If `req`=0: stay IDLE; all outputs hold. `sel` keeps its last value.
- Otherwise: with `o` = `pick(req, ptr)`, set `grant` ← one-hot(`o`), `sel` ← `o`, `cnt` ← 1, and go to GRANT.

State GRANT, owner `o`, at each edge:
- **Release** when `req[o]`=0, or when `cnt`=`BURST_LEN`.
- On release:
  - `ptr` ← `o`+1 mod 4.
  - If `pick(req, o+1)` returns `n`: `grant` ← one-hot(`n`), `sel` ← `n`, `cnt` ← 1, stay in GRANT. There is no idle bubble between owners.
  - If it returns none: `grant` ← 0, go to IDLE. `sel` holds.
- No release: `cnt` ← `cnt`+1; `grant` and `sel` hold.

Fairness:
- `o` itself is the lowest-priority candidate at its own release.
- If `o` is the sole requester when its burst expires, it is re-granted immediately with a fresh `cnt`=1.

Other rules:
- Requests rising or falling for non-owners mid-burst have no effect until the next release.
- `selValid` = OR of `grant`.
- `lastCycle` = (state GRANT) AND (`cnt`=`BURST_LEN`).
- Both `selValid` and `lastCycle` are combinational from registers only, with no path from `req`.
- `BURST_LEN`=1: every GRANT cycle is a release cycle. Grant rotates every cycle among active requesters.

## Timing

- Request-to-grant latency: 1 cycle from IDLE. `req` is sampled at edge k; `grant` is valid after edge k.
- Owner drops `req[o]` in cycle c: `grant[o]` stays high through cycle c (one-cycle overhang) and changes at the edge ending c.
- Maximum continuous grant: `BURST_LEN` cycles.
- Worst-case wait for a continuously requesting requester: 3×`BURST_LEN` cycles after its request is sampled, plus 1 cycle.
- Owner hand-off: `grant` switches one-hot to one-hot in a single edge. No cycle ever has two grant bits high.
- `sel` changes only on the same edge as a new grant.

## Test plan

1. **Reset:** hold `reset`=1 for 2 cycles with `req`=1111. Expect `grant`=0000, `sel`=00, `selValid`=0. Release reset; next edge `grant`=0001, `sel`=00.
2. **Single requester burst:** `BURST_LEN`=4, `req`=0100 held. Expect `grant`=0100 and `sel`=10 continuously. `lastCycle` pulses every 4th cycle; no gap in `grant`.
3. **Round-robin rotation:** `req`=1111 held from IDLE with `ptr`=0. Expect `grant` sequence 0001, 0010, 0100, 1000, 0001, with 4 cycles each and zero bubbles. `sel` follows 00, 01, 10, 11.
4. **Early drop:** `req`=0011, requester 0 granted. Drop `req[0]` in its 2nd grant cycle. Expect `grant[0]` high for exactly 2 cycles, then `grant`=0010. After requester 1 releases with `req`=0000, expect `grant`=0000 and `sel` still 01.
5. **Priority after release:** owner 3 finishes its burst with `req`=1001. Expect next `grant`=0001, because `ptr` wraps 3→0.
6. **Reset mid-burst:** assert `reset` during cycle 2 of owner 2's burst. Expect `grant`=0000 and `sel`=00 at the next edge. After reset deasserts with `req`=0100, expect a fresh burst of 4 cycles.
